decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PEND_W, default 3, width of the outstanding-cell-write counter.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port ins  in  16  instruction from fetch; 16'h0000 = NOP while fetch disabled.
REQ-005 SHALL have port dp  in  16  current data pointer from execute.
REQ-006 SHALL have port cell_zero  in  1  current cell == 0, meaningful only when no writes are pending.
REQ-007 SHALL have port wr_done  in  1  one-cycle pulse when execute retires one ADD or IN cell write.
REQ-008 SHALL have port stall  out  1  fetch hold request.
REQ-009 SHALL have port branch_en  out  1  fetch redirect strobe.
REQ-010 SHALL have port branch_val  out  16  redirect target.
REQ-011 SHALL have port fork_cxt  out  33  {valid, child dp[15:0], child pc[15:0]} to sibling core fetch.
REQ-012 SHALL have ports ex_valid out 1, ex_op out 4, ex_imm out 12: registered issue to execute.
REQ-013 SHALL have port halted  out  1  core has executed HALT.

Function
REQ-014 SHALL decode ins[15:12] as op: 0 NOP, 1 ADD, 2 MOVE, 3 JZ, 4 JNZ, 5 OUT, 6 IN, 7 FORK, 8 HALT, 9-15 NOP; ins[11:0] = imm.
REQ-015 SHALL capture ins into ins_q on each edge where stall is low and state is RUN; no capture while stall high.
REQ-016 SHALL implement FSM states RUN, WAIT_COND, SQUASH, HALTED.
REQ-017 RUN: ADD/MOVE/OUT/IN in ins_q SHALL issue next cycle (ex_valid=1, ex_op, ex_imm); NOP issues nothing.
REQ-018 SHALL count pending writes: +1 on ADD/IN issue, -1 on wr_done, net 0 if both in same cycle.
REQ-019 ADD/IN in ins_q with pending at all-ones SHALL assert stall and not issue until a wr_done frees a slot.
REQ-020 JZ/JNZ in ins_q SHALL go to WAIT_COND with stall high; exit once pending == 0, in the same cycle evaluating cell_zero.
REQ-021 Taken branch (JZ & cell_zero, or JNZ & !cell_zero) SHALL pulse branch_en one cycle, branch_val = {4'h0, imm}, then enter SQUASH.
REQ-022 Not-taken branch SHALL return to RUN, drop stall, no branch_en.
REQ-023 SQUASH SHALL last exactly one cycle, discard the wrong-path ins without issue, then return to RUN.
REQ-024 FORK in ins_q SHALL pulse fork_cxt for one cycle = {1'b1, dp + 16'h0001, {4'h0, imm}}; no ex_valid.
REQ-025 HALT SHALL enter HALTED: stall=1, halted=1, ex_valid=0, branch_en=0; exit only by reset.
REQ-026 branch_en and fork_cxt[32] SHALL never be high in the same cycle.
REQ-027 dp + 1 SHALL wrap 16'hFFFF -> 16'h0000.
REQ-028 wr_done with pending == 0 SHALL be ignored; counter never underflows.

Reset
REQ-029 rst_n low at a rising edge SHALL force state RUN, pending 0, ins_q NOP, and on the next cycle stall 0, branch_en 0, branch_val 0, fork_cxt 0, ex_valid 0, ex_op 0, ex_imm 0, halted 0.
REQ-030 Reset during WAIT_COND, SQUASH or HALTED SHALL abandon the operation, with no branch_en or fork_cxt pulse afterwards.

Configuration
REQ-031 Macro DECODE_FORK_EN defined: FORK behaves per REQ-024.
REQ-032 DECODE_FORK_EN undefined: fork_cxt is constant 0 and FORK decodes as NOP.

Verification
REQ-033 ins 0x1005 then 0x2FFF, no stalls -> ex_op 1 imm 0x005 then ex_op 2 imm 0xFFF on consecutive cycles; pending 1.
REQ-034 pending 2, JZ 0x3123 -> stall held until two wr_done pulses; cell_zero=1 -> branch_en one cycle, branch_val 0x0123, next ins discarded.
REQ-035 JNZ 0x4040 with cell_zero=1, pending 0 -> no branch_en, stall high one cycle, next instruction issues.
REQ-036 dp 0xFFFF, FORK 0x7200 (DECODE_FORK_EN) -> fork_cxt = {1, 0x0000, 0x0200} one cycle; without macro -> fork_cxt stays 0.
REQ-037 Eight back-to-back ADDs, no wr_done -> seven issue, eighth stalls; one wr_done -> eighth issues next cycle.
REQ-038 HALT 0x8000 then rst_n low one cycle -> halted 1 and stall 1 until reset; all outputs 0 after reset; ADD 0x1001 then issues normally.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage -- instruction decode / issue stage of a small cell-machine core.
//
// Purpose:
//   Latches the fetched instruction, issues ALU/IO operations to execute,
//   tracks outstanding cell writes, resolves conditional branches once all
//   writes have retired, and handles FORK and HALT.
//
// Ports:
//   clk         in   1   sole clock, rising edge
//   rst_n       in   1   synchronous active-low reset
//   ins         in  16   instruction from fetch (16'h0000 = NOP)
//   dp          in  16   current data pointer from execute
//   cell_zero   in   1   current cell == 0 (valid when no writes pending)
//   wr_done     in   1   execute retired one ADD/IN cell write
//   stall       out  1   fetch hold request
//   branch_en   out  1   fetch redirect strobe
//   branch_val  out 16   redirect target
//   fork_cxt    out 33   {valid, child dp, child pc} to sibling core
//   ex_valid    out  1   registered issue strobe to execute
//   ex_op       out  4   issued opcode
//   ex_imm      out 12   issued immediate
//   halted      out  1   core has executed HALT
//
// Configuration:
//   DECODE_FORK_EN  defined   -> FORK pulses fork_cxt for one cycle
//                   undefined -> FORK decodes as NOP, fork_cxt tied to 0

module decode_stage #(
  parameter int PEND_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ins,
  input  logic [15:0] dp,
  input  logic        cell_zero,
  input  logic        wr_done,
  output logic        stall,
  output logic        branch_en,
  output logic [15:0] branch_val,
  output logic [32:0] fork_cxt,
  output logic        ex_valid,
  output logic [3:0]  ex_op,
  output logic [11:0] ex_imm,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_WAIT_COND = 2'd1,
    S_SQUASH    = 2'd2,
    S_HALTED    = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_MOVE = 4'd2;
  localparam logic [3:0] OP_JZ   = 4'd3;
  localparam logic [3:0] OP_JNZ  = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_IN   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd8;

  localparam logic [PEND_W-1:0] PEND_ONE = 1;

  state_t              r_state;
  state_t              w_nextState;
  logic [15:0]         r_insQ;
  logic [PEND_W-1:0]   r_pending;
  logic [11:0]         r_branchImm;
  logic                r_branchIsJnz;
  logic                r_exValid;
  logic [3:0]          r_exOp;
  logic [11:0]         r_exImm;
  logic                r_branchEn;
  logic [15:0]         r_branchVal;

  logic [3:0]          w_op;
  logic [11:0]         w_imm;
  logic                w_isAddIn;
  logic                w_isIssueOp;
  logic                w_isBranch;
  logic                w_isFork;
  logic                w_isHalt;
  logic                w_full;
  logic                w_condReady;
  logic                w_taken;
  logic                w_stall;
  logic                w_issue;
  logic                w_fork;
  logic                w_branchTake;
  logic                w_capture;
  logic                w_inc;
  logic                w_dec;

  assign w_op        = r_insQ[15:12];
  assign w_imm       = r_insQ[11:0];
  assign w_isAddIn   = (w_op == OP_ADD) || (w_op == OP_IN);
  assign w_isIssueOp = w_isAddIn || (w_op == OP_MOVE) || (w_op == OP_OUT);
  assign w_isBranch  = (w_op == OP_JZ) || (w_op == OP_JNZ);
  assign w_isHalt    = (w_op == OP_HALT);
`ifdef DECODE_FORK_EN
  assign w_isFork    = (w_op == 4'd7);
`else
  assign w_isFork    = 1'b0;
`endif

  // cell_zero only reflects the real cell once every write has retired.
  assign w_full      = &r_pending;
  assign w_condReady = (r_pending == '0);
  assign w_taken     = r_branchIsJnz ? !cell_zero : cell_zero;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_RUN: begin
        if (w_isBranch) begin
          w_nextState = S_WAIT_COND;
        end else if (w_isHalt) begin
          w_nextState = S_HALTED;
        end
      end
      S_WAIT_COND: begin
        if (w_condReady) begin
          w_nextState = w_taken ? S_SQUASH : S_RUN;
        end
      end
      S_SQUASH: w_nextState = S_RUN;
      S_HALTED: w_nextState = S_HALTED;
      default:  w_nextState = S_RUN;
    endcase
  end

  // Output / control decode. A full write counter only blocks ADD/IN when no
  // slot is freed in the same cycle, so the retire and the issue net to zero.
  always_comb begin
    w_stall      = 1'b0;
    w_issue      = 1'b0;
    w_fork       = 1'b0;
    w_branchTake = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_stall   = w_isAddIn && w_full && !wr_done;
        w_issue   = w_isIssueOp && !w_stall;
        w_fork    = w_isFork;
        w_capture = !w_stall;
      end
      S_WAIT_COND: begin
        w_stall      = 1'b1;
        w_branchTake = w_condReady && w_taken;
      end
      S_SQUASH: w_stall = 1'b1;
      S_HALTED: w_stall = 1'b1;
      default:  w_stall = 1'b0;
    endcase
  end

  assign w_inc = w_issue && w_isAddIn;
  assign w_dec = wr_done && (r_pending != '0);

  // Datapath: instruction latch, write counter, branch bookkeeping and the
  // registered issue/redirect outputs. The fall-through instruction latched
  // alongside a branch is dropped when leaving SQUASH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_insQ        <= '0;
      r_pending     <= '0;
      r_branchImm   <= '0;
      r_branchIsJnz <= 1'b0;
      r_exValid     <= 1'b0;
      r_exOp        <= '0;
      r_exImm       <= '0;
      r_branchEn    <= 1'b0;
      r_branchVal   <= '0;
    end else begin
      if (w_capture) begin
        r_insQ <= ins;
      end else if (r_state == S_SQUASH) begin
        r_insQ <= '0;
      end

      if (w_inc && !w_dec) begin
        r_pending <= r_pending + PEND_ONE;
      end else if (w_dec && !w_inc) begin
        r_pending <= r_pending - PEND_ONE;
      end

      if ((r_state == S_RUN) && w_isBranch) begin
        r_branchImm   <= w_imm;
        r_branchIsJnz <= (w_op == OP_JNZ);
      end

      r_exValid <= w_issue;
      if (w_issue) begin
        r_exOp  <= w_op;
        r_exImm <= w_imm;
      end

      r_branchEn <= w_branchTake;
      if (w_branchTake) begin
        r_branchVal <= {4'h0, r_branchImm};
      end
    end
  end

`ifdef DECODE_FORK_EN
  logic [32:0] r_forkCxt;

  // Child context: data pointer one past the parent (wrapping), pc = imm.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_forkCxt <= '0;
    end else if (w_fork) begin
      r_forkCxt <= {1'b1, dp + 16'h0001, 4'h0, w_imm};
    end else begin
      r_forkCxt <= '0;
    end
  end

  assign fork_cxt = r_forkCxt;
`else
  logic w_unusedFork;
  assign w_unusedFork = (^dp) ^ w_fork;
  assign fork_cxt     = '0;
`endif

  assign stall      = w_stall;
  assign halted     = (r_state == S_HALTED);
  assign branch_en  = r_branchEn;
  assign branch_val = r_branchVal;
  assign ex_valid   = r_exValid;
  assign ex_op      = r_exOp;
  assign ex_imm     = r_exImm;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- self-checking bench for decode_stage.
// Issued operations are tracked in a scoreboard queue: every instruction
// that should reach execute is pushed when driven and popped when ex_valid
// shows it. Cycle-exact checks cover stalls, branches, fork and halt.

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins;
  logic [15:0] dp;
  logic        cell_zero;
  logic        wr_done;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_val;
  logic [32:0] fork_cxt;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [11:0] ex_imm;
  logic        halted;

  logic [15:0] sb[$];
  logic [15:0] expIssue;
  logic [32:0] expFork;
  int          checkCount = 0;
  int          failCount  = 0;

  always #5 clk = ~clk;

  decode_stage #(.PEND_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ins        (ins),
    .dp         (dp),
    .cell_zero  (cell_zero),
    .wr_done    (wr_done),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_val (branch_val),
    .fork_cxt   (fork_cxt),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_imm     (ex_imm),
    .halted     (halted)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then leave a
  // small gap so combinational outputs settle before the caller samples.
  task automatic applyStimulus(input logic [15:0] i, input logic [15:0] d,
                               input logic cz, input logic wd);
    @(negedge clk);
    ins       = i;
    dp        = d;
    cell_zero = cz;
    wr_done   = wd;
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".stall"},     stall,      0);
    checkOutput({tag, ".branchEn"},  branch_en,  0);
    checkOutput({tag, ".branchVal"}, branch_val, 0);
    checkOutput({tag, ".forkCxt"},   fork_cxt,   0);
    checkOutput({tag, ".exValid"},   ex_valid,   0);
    checkOutput({tag, ".exOp"},      ex_op,      0);
    checkOutput({tag, ".exImm"},     ex_imm,     0);
    checkOutput({tag, ".halted"},    halted,     0);
  endtask

  // Scoreboard monitor: every issue must match the oldest expected entry.
  // An issue with nothing expected is compared against an opcode that
  // can never be issued, so it always reports.
  always @(posedge clk) begin
    #1;
    if (ex_valid === 1'b1) begin
      expIssue = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
      checkOutput("issue", {ex_op, ex_imm}, expIssue);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ins = '0; dp = 16'h1234; cell_zero = 1'b0; wr_done = 1'b0;

    // Reset state.
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Back-to-back ADD then MOVE issue on consecutive cycles.
    sb.push_back(16'h1005); applyStimulus(16'h1005, 16'h1234, 0, 0);
    sb.push_back(16'h2FFF); applyStimulus(16'h2FFF, 16'h1234, 0, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("A.exValid0", ex_valid, 1);
    checkOutput("A.exOp0",    ex_op,    4'h1);
    checkOutput("A.exImm0",   ex_imm,   12'h005);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("A.exValid1", ex_valid, 1);
    checkOutput("A.exOp1",    ex_op,    4'h2);
    checkOutput("A.exImm1",   ex_imm,   12'hFFF);

    // Pending goes to 2, JZ waits for both retires, then taken and squash.
    sb.push_back(16'h1003); applyStimulus(16'h1003, 16'h1234, 0, 0);
    applyStimulus(16'h3123, 16'h1234, 0, 0);
    applyStimulus(16'h2777, 16'h1234, 0, 0);
    checkOutput("B.stallRun", stall, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("B.stallW0", stall, 1);
    applyStimulus(16'h0000, 16'h1234, 0, 1);
    checkOutput("B.stallW1", stall, 1);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("B.stallW2", stall, 1);
    applyStimulus(16'h0000, 16'h1234, 0, 1);
    checkOutput("B.stallW3", stall, 1);
    checkOutput("B.noEarlyBr", branch_en, 0);
    applyStimulus(16'h0000, 16'h1234, 1, 0);
    checkOutput("B.stallEval", stall, 1);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("B.branchEn",  branch_en,  1);
    checkOutput("B.branchVal", branch_val, 16'h0123);
    checkOutput("B.stallSq",   stall,      1);
    sb.push_back(16'h5055); applyStimulus(16'h5055, 16'h1234, 0, 0);
    checkOutput("B.branchEnOff", branch_en, 0);
    checkOutput("B.stallOff",    stall,     0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);

    // JNZ not taken with pending 0: one stall cycle, fall-through issues.
    applyStimulus(16'h4040, 16'h1234, 1, 0);
    sb.push_back(16'h6011); applyStimulus(16'h6011, 16'h1234, 1, 0);
    checkOutput("C.stallRun", stall, 0);
    applyStimulus(16'h0000, 16'h1234, 1, 0);
    checkOutput("C.stallWait", stall, 1);
    applyStimulus(16'h0000, 16'h1234, 1, 0);
    checkOutput("C.stallOff", stall,     0);
    checkOutput("C.noBranch", branch_en, 0);
    applyStimulus(16'h0000, 16'h1234, 1, 1);
    checkOutput("C.exValid",   ex_valid,  1);
    checkOutput("C.exOp",      ex_op,     4'h6);
    checkOutput("C.noBranch2", branch_en, 0);

    // FORK with dp wrapping from FFFF.
`ifdef DECODE_FORK_EN
    expFork = {1'b1, 16'h0000, 16'h0200};
`else
    expFork = '0;
`endif
    applyStimulus(16'h7200, 16'hFFFF, 0, 0);
    applyStimulus(16'h0000, 16'hFFFF, 0, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("D.forkCxt",  fork_cxt,  expFork);
    checkOutput("D.exValid",  ex_valid,  0);
    checkOutput("D.branchEn", branch_en, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("D.forkOff", fork_cxt, 0);

    // Eight ADDs: seven issue, the eighth waits for a retire.
    for (int i = 1; i <= 8; i++) begin
      sb.push_back(16'h1000 | 16'(i));
      applyStimulus(16'h1000 | 16'(i), 16'h1234, 0, 0);
    end
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("E.stallFull", stall, 1);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("E.stallHold", stall,    1);
    checkOutput("E.noIssue",   ex_valid, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 1);
    checkOutput("E.stallFreed", stall, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("E.exValid", ex_valid, 1);
    checkOutput("E.exImm",   ex_imm,   12'h008);
    // Drain all seven writes, then two spurious retires that must be ignored.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(16'h0000, 16'h1234, 0, 1);
    end
    applyStimulus(16'h3010, 16'h1234, 1, 0);
    applyStimulus(16'h0000, 16'h1234, 1, 0);
    checkOutput("E.jzRun", stall, 0);
    applyStimulus(16'h0000, 16'h1234, 1, 0);
    checkOutput("E.jzWait", stall, 1);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("E.jzTaken", branch_en,  1);
    checkOutput("E.jzVal",   branch_val, 16'h0010);
    applyStimulus(16'h0000, 16'h1234, 0, 0);

    // Reset while waiting on a branch abandons it.
    sb.push_back(16'h1002); applyStimulus(16'h1002, 16'h1234, 1, 0);
    applyStimulus(16'h3020, 16'h1234, 1, 0);
    applyStimulus(16'h0000, 16'h1234, 1, 0);
    applyStimulus(16'h0000, 16'h1234, 1, 0);
    checkOutput("F.waiting", stall, 1);
    rst_n = 1'b0;
    applyStimulus(16'h0000, 16'h1234, 1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0000, 16'h1234, 1, 0);
      checkOutput("F.noBranch", branch_en, 0);
      checkOutput("F.noStall",  stall,     0);
    end

    // HALT holds until reset; then normal issue resumes.
    applyStimulus(16'h8000, 16'h1234, 0, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("G.stallRun", stall, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h1003, 16'h1234, 0, 0);
      checkOutput("G.halted",  halted,    1);
      checkOutput("G.stall",   stall,     1);
      checkOutput("G.exValid", ex_valid,  0);
      checkOutput("G.branch",  branch_en, 0);
    end
    rst_n = 1'b0;
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkResetOutputs("G.reset");
    rst_n = 1'b1;
    sb.push_back(16'h1001); applyStimulus(16'h1001, 16'h1234, 0, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("G.exValid", ex_valid, 1);
    checkOutput("G.exOp",    ex_op,    4'h1);
    checkOutput("G.exImm",   ex_imm,   12'h001);

    applyStimulus(16'h0000, 16'h1234, 0, 0);
    applyStimulus(16'h0000, 16'h1234, 0, 0);
    checkOutput("sbDrained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
